para_alu_seq: RTL and testbench

- Parametrised W-bit sequential ALU. It is the successor to the combinational ripple ALU slice array.
- Adds registered outputs, valid/ready handshakes on input and output, status flags, and multi-cycle shift and multiply ops driven by an internal FSM.
- Sits between the operand-fetch stage and the writeback stage of the datapath. One operation is in flight at a time.

---
 rtl/para_alu_seq.sv | 146 ++++++++++++++
 tb/tb_para_alu_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/para_alu_seq.sv
// para_alu_seq: handshaked W-bit ALU with registered result/flags; shifts step 1 bit per cycle.
// Define PARA_ALU_MUL_EN to build the W-cycle shift-add multiplier for opcode 111.
module para_alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic [2:0]   operation,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         zero,
  output logic         ovf
);
  localparam int SHW = $clog2(W);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic ready_q;
  logic [2:0] op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] lo_q, lo_d, result_q, result_d;
  logic c_out_q, c_out_d, zero_q, zero_d, ovf_q, ovf_d;
  logic sub, arith, is_sh, is_mul, accept, busy_c, ovf_i;
  logic [W-1:0] bx, res_i;
  logic [W:0] sum;
`ifdef PARA_ALU_MUL_EN
  logic [W-1:0] a_q, a_d, hi_q, hi_d;
  logic [W:0] msum;
  assign is_mul = operation == 3'b111 && |a && |b;
`else
  assign is_mul = 1'b0;
`endif
  assign sub = operation == 3'b011;
  assign arith = operation == 3'b010 || sub;
  assign bx = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub | c_in};
  assign ovf_i = arith && (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
  assign is_sh = (operation == 3'b101 || operation == 3'b110) && |b[SHW-1:0];
  assign accept = in_valid && ready_q;
  // Shifts reach here only with a zero amount, so they pass a through; disabled MUL yields 0.
  assign res_i = operation == 3'b000 ? a & b :
                 operation == 3'b001 ? a | b :
                 arith ? sum[W-1:0] :
                 operation == 3'b100 ? {{(W-1){1'b0}}, $signed(a) < $signed(b)} :
                 (operation == 3'b101 || operation == 3'b110) ? a : '0;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    lo_d = lo_q;
    result_d = result_q;
    c_out_d = c_out_q;
    zero_d = zero_q;
    ovf_d = ovf_q;
    busy_c = 1'b0;
`ifdef PARA_ALU_MUL_EN
    a_d = a_q;
    hi_d = hi_q;
    msum = {1'b0, hi_q} + {1'b0, lo_q[0] ? a_q : {W{1'b0}}};
`endif
    case (state_q)
      IDLE: if (accept) begin
        op_d = operation;
        if (is_sh || is_mul) begin
          state_d = BUSY;
          cnt_d = is_mul ? CW'(W) : CW'(b[SHW-1:0]);
          lo_d = is_mul ? b : a;
`ifdef PARA_ALU_MUL_EN
          a_d = a;
          hi_d = '0;
`endif
        end else begin
          state_d = DONE;
          result_d = res_i;
          c_out_d = arith && sum[W];
          zero_d = res_i == '0;
          ovf_d = ovf_i;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        lo_d = op_q == 3'b101 ? {lo_q[W-2:0], 1'b0} : {1'b0, lo_q[W-1:1]};
`ifdef PARA_ALU_MUL_EN
        if (op_q == 3'b111) begin
          hi_d = msum[W:1];
          lo_d = {msum[0], lo_q[W-1:1]};
          busy_c = |msum[W:1];
        end
`endif
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          result_d = lo_d;
          c_out_d = busy_c;
          zero_d = lo_d == '0;
          ovf_d = 1'b0;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      op_q <= '0;
      cnt_q <= '0;
      lo_q <= '0;
      result_q <= '0;
      c_out_q <= 1'b0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef PARA_ALU_MUL_EN
      a_q <= '0;
      hi_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= state_d == IDLE;
      op_q <= op_d;
      cnt_q <= cnt_d;
      lo_q <= lo_d;
      result_q <= result_d;
      c_out_q <= c_out_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
`ifdef PARA_ALU_MUL_EN
      a_q <= a_d;
      hi_q <= hi_d;
`endif
    end
  end
  assign in_ready = ready_q;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign c_out = c_out_q;
  assign zero = zero_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_para_alu_seq.sv
// tb_para_alu_seq: randomized and directed checks of para_alu_seq (W=8) against an arithmetic reference model.
module tb_para_alu_seq;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, c_in, out_valid, out_ready, c_out, zero, ovf;
  logic [7:0] a, b, result;
  logic [2:0] operation;
  int errors = 0;
  int checks = 0;
  typedef struct packed {
    logic [7:0] r;
    logic c;
    logic z;
    logic v;
    logic [7:0] lat;
  } exp_t;
  para_alu_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .operation(operation),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .c_out(c_out), .zero(zero), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input logic ci);
    exp_t e;
    int xs, ys, s, n, p;
    e = '0;
    e.lat = 8'd1;
    xs = int'($signed(x));
    ys = int'($signed(y));
    n = int'(y[2:0]);
    p = 0;
    case (op)
      3'd0: e.r = x & y;
      3'd1: e.r = x | y;
      3'd2: begin
        s = int'(x) + int'(y) + int'(ci);
        e.r = 8'(s);
        e.c = s > 255;
        s = xs + ys + int'(ci);
        e.v = s > 127 || s < -128;
      end
      3'd3: begin
        e.r = x - y;
        e.c = x >= y;
        s = xs - ys;
        e.v = s > 127 || s < -128;
      end
      3'd4: e.r = xs < ys ? 8'd1 : 8'd0;
      3'd5: begin
        e.r = 8'(int'(x) << n);
        e.lat = 8'(n + 1);
      end
      3'd6: begin
        e.r = x >> n;
        e.lat = 8'(n + 1);
      end
      default: begin
`ifdef PARA_ALU_MUL_EN
        p = int'(x) * int'(y);
        e.r = 8'(p);
        e.c = p > 255;
        e.lat = (x != 0 && y != 0) ? 8'd9 : 8'd1;
`else
        e.r = 8'd0;
`endif
      end
    endcase
    e.z = e.r == 8'd0;
    return e;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y, input logic ci, input int hold);
    exp_t e;
    int g, lat;
    logic busy_ok, stab_ok;
    e = model(op, x, y, ci);
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    chk("ready_before_op", 32'(in_ready), 32'd1);
    operation = op;
    a = x;
    b = y;
    c_in = ci;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    c_in = 1'($urandom);
    operation = 3'($urandom);
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 64) begin
      if (in_ready) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("latency", 32'(lat), 32'(e.lat));
    chk("in_ready_low_busy", 32'(busy_ok), 32'd1);
    chk("result", 32'(result), 32'(e.r));
    chk("c_out", 32'(c_out), 32'(e.c));
    chk("zero", 32'(zero), 32'(e.z));
    chk("ovf", 32'(ovf), 32'(e.v));
    stab_ok = 1'b1;
    repeat (hold) begin
      tick();
      if (!out_valid || in_ready || result !== e.r || c_out !== e.c || zero !== e.z || ovf !== e.v)
        stab_ok = 1'b0;
    end
    chk("hold_stable", 32'(stab_ok), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(out_valid), 32'd0);
    chk("in_ready_return", 32'(in_ready), 32'd1);
  endtask
  initial begin
    logic [2:0] rop;
    logic [7:0] rx, ry;
    logic quiet;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    operation = '0;
    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({c_out, zero, ovf}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    run_op(3'd2, 8'hFF, 8'h01, 1'b0, 0);
    run_op(3'd3, 8'h80, 8'h01, 1'b1, 0);
    run_op(3'd3, 8'h80, 8'h01, 1'b0, 0);
    run_op(3'd5, 8'h03, 8'h05, 1'b0, 0);
    run_op(3'd6, 8'h80, 8'h00, 1'b0, 0);
    run_op(3'd6, 8'hA5, 8'hF7, 1'b0, 1);
    run_op(3'd7, 8'h10, 8'h11, 1'b0, 0);
    run_op(3'd7, 8'h00, 8'h37, 1'b0, 0);
    run_op(3'd2, 8'h05, 8'h06, 1'b0, 5);
    run_op(3'd2, 8'h7F, 8'h01, 1'b1, 0);
    run_op(3'd4, 8'h80, 8'h01, 1'b0, 0);
    run_op(3'd4, 8'h01, 8'h80, 1'b0, 0);
    // Abort a long op in its 4th BUSY cycle.
`ifdef PARA_ALU_MUL_EN
    operation = 3'd7;
    a = 8'h10;
    b = 8'h11;
`else
    operation = 3'd5;
    a = 8'h81;
    b = 8'h07;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'({c_out, zero, ovf}), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("abort_ready_back", 32'(in_ready), 32'd1);
    quiet = 1'b1;
    repeat (12) begin
      if (out_valid) quiet = 1'b0;
      tick();
    end
    chk("abort_no_result", 32'(quiet), 32'd1);
    run_op(3'd2, 8'h21, 8'h12, 1'b1, 0);
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      rx = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      ry = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
      run_op(rop, rx, ry, 1'($urandom), $urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
